// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared constants and FSM state type for the register dump engine.
// Defining REG_DUMP_CHECKSUM_EN appends an XOR checksum word to every dump.
package reg_dump_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int TOTAL_WORDS = NUM_REGS + 1;
`else
  localparam int TOTAL_WORDS = NUM_REGS;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump.sv
// reg_dump: walks register-file indices on a spare read port and streams each value out
// over valid/ready. REG_DUMP_CHECKSUM_EN adds a trailing XOR checksum word (index 0, last).
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = reg_dump_pkg::ADDR_W,
  parameter int NUM_REGS = reg_dump_pkg::NUM_REGS
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Start,
  output logic              Busy,
  output logic [ADDR_W-1:0] Ra,
  input  logic [DATA_W-1:0] Qa,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [ADDR_W-1:0] Out_Index,
  output logic              Out_Last,
  output logic              Done
);

  // The word counter needs one bit beyond ADDR_W so it can reach the checksum slot without wrapping.
  localparam int N_WORDS = NUM_REGS + (TOTAL_WORDS - reg_dump_pkg::NUM_REGS);
  localparam int CNT_W   = $clog2(N_WORDS + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ra_q, ra_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          cnt_d   = '0;
          state_d = READ;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        data_d  = Qa;
        index_d = cnt_q[ADDR_W-1:0];
        last_d  = (cnt_q == CNT_W'(N_WORDS - 1));
`ifdef REG_DUMP_CHECKSUM_EN
        // The slot after the last register carries the accumulated XOR instead of Qa.
        if (cnt_q == CNT_W'(NUM_REGS)) begin
          data_d  = csum_q;
          index_d = '0;
        end else begin
          csum_d  = csum_q ^ Qa;
        end
`endif
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && Out_Ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = READ;
          end
        end else begin
          state_d = SEND;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    if (state_d == READ && cnt_d < CNT_W'(NUM_REGS)) begin
      ra_d = cnt_d[ADDR_W-1:0];
    end else begin
      ra_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ra_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign Busy      = busy_q;
  assign Ra        = ra_q;
  assign Out_Valid = valid_q;
  assign Out_Data  = data_q;
  assign Out_Index = index_q;
  assign Out_Last  = last_q;
  assign Done      = done_q;

endmodule
